// File: rtl/disp_scan_arb.sv
// 4-digit 7-segment scan driver with a two-requester round-robin write port; SEG_PWM_EN adds brightness.
// Latency: a write is acked one cycle after request and reaches sseg from the next edge; outputs registered.
// Backpressure: a losing or just-granted requester holds req/sel/data until its gnt pulse.
module disp_scan_arb #(
    parameter int N     = 18,
    parameter int DEAD  = 4,
    parameter int PWM_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic [1:0]           a_sel,
    input  logic [7:0]           a_data,
    output logic                 a_gnt,
    input  logic                 b_req,
    input  logic [1:0]           b_sel,
    input  logic [7:0]           b_data,
    output logic                 b_gnt,
`ifdef SEG_PWM_EN
    input  logic [PWM_W-1:0]     brightness,
`endif
    output logic [3:0]           an,
    output logic [7:0]           sseg
);

    localparam logic [N-3:0] DEAD_OFF = DEAD[N-3:0];

    logic [N-1:0] q;
    logic [7:0]   d [4];
    logic         rr_b_last;

    logic         a_elig;
    logic         b_elig;
    logic         a_win;
    logic         b_win;
    logic         tie;

    logic [1:0]   slot;
    logic [N-3:0] off;
    logic [PWM_W:0] duty;
    logic         lit;

    // Ack pulse doubles as a one-cycle lockout for the same requester.
    assign a_elig = a_req & ~a_gnt;
    assign b_elig = b_req & ~b_gnt;
    assign tie    = a_elig & b_elig;
    assign a_win  = a_elig & (~b_elig | rr_b_last);
    assign b_win  = b_elig & ~a_win;

    assign slot = q[N-1:N-2];
    assign off  = q[N-3:0];

    // Without PWM the threshold sits above every offset value, giving full duty.
`ifdef SEG_PWM_EN
    assign duty = {1'b0, brightness};
`else
    assign duty = {1'b1, {PWM_W{1'b0}}};
`endif

    assign lit = (off >= DEAD_OFF) && ({1'b0, off[PWM_W-1:0]} < duty);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q         <= '0;
            rr_b_last <= 1'b1;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            an        <= 4'b1111;
            sseg      <= 8'hFF;
            for (int i = 0; i < 4; i++) begin
                d[i] <= 8'hFF;
            end
        end else begin
            q     <= q + 1'b1;
            a_gnt <= a_win;
            b_gnt <= b_win;
            if (tie) begin
                rr_b_last <= b_win;
            end
            if (a_win) begin
                d[a_sel] <= a_data;
            end
            if (b_win) begin
                d[b_sel] <= b_data;
            end
            if (lit) begin
                an   <= ~(4'b0001 << slot);
                sseg <= d[slot];
            end else begin
                an   <= 4'b1111;
                sseg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_arb.sv
// Scoreboard bench for disp_scan_arb at N=6, DEAD=2 (16-cycle slots, 64-cycle frame).
module tb_disp_scan_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_req, b_req, a_gnt, b_gnt;
    logic [1:0] a_sel, b_sel;
    logic [7:0] a_data, b_data;
    logic [3:0] an;
    logic [7:0] sseg;
`ifdef SEG_PWM_EN
    logic [3:0] brightness;
    logic [3:0] bright_m;
`endif

    disp_scan_arb #(.N(6), .DEAD(2), .PWM_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_sel(a_sel), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_sel(b_sel), .b_data(b_data), .b_gnt(b_gnt),
`ifdef SEG_PWM_EN
        .brightness(brightness),
`endif
        .an(an), .sseg(sseg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit is_b; } gnt_e_t;
    typedef struct { int cyc; logic [3:0] an; logic [7:0] ss; } disp_e_t;

    gnt_e_t  gq[$];
    disp_e_t dq[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      rel     = 0;
    logic [7:0] exp_d [4];
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input int c, input bit is_b);
        gnt_e_t e;
        e.cyc  = c;
        e.is_b = is_b;
        gq.push_back(e);
    endtask

    task automatic exp_disp(input int c, input logic [3:0] a, input logic [7:0] s);
        disp_e_t e;
        e.cyc = c;
        e.an  = a;
        e.ss  = s;
        dq.push_back(e);
    endtask

    // Output seen in cycle e reflects counter value e-rel-1, rel being the last reset edge.
    task automatic push_model(input int e);
        int   t, slot, off;
        logic lit;
        t    = (e - rel - 1) % 64;
        slot = t / 16;
        off  = t % 16;
        lit  = (off >= 2);
`ifdef SEG_PWM_EN
        lit  = lit && (off < int'(bright_m));
`endif
        if (lit) exp_disp(e, an_tab[slot], exp_d[slot]);
        else     exp_disp(e, 4'b1111, 8'hFF);
    endtask

    task automatic check_frame(input string name);
        int i;
        for (int k = 2; k <= 65; k++) push_model(cyc + k);
        i = 0;
        while (dq.size() > 0 && i < 100) begin
            tick();
            i++;
        end
        if (dq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s drain: %0d display entries left, required 0", name, dq.size());
            dq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (a_gnt || b_gnt) begin
            n_tests++;
            if (gq.size() == 0) begin
                n_fail++;
                $display("FAIL gnt_unexpected cyc=%0d a_gnt=%b b_gnt=%b, required none", cyc, a_gnt, b_gnt);
            end else begin
                gnt_e_t g;
                g = gq.pop_front();
                if (g.cyc != cyc || a_gnt == b_gnt || b_gnt != g.is_b) begin
                    n_fail++;
                    $display("FAIL gnt cyc=%0d a_gnt=%b b_gnt=%b, required %s at cyc=%0d",
                             cyc, a_gnt, b_gnt, g.is_b ? "B" : "A", g.cyc);
                end
            end
        end
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            gnt_e_t g;
            g = gq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL gnt_missing no grant seen, required %s at cyc=%0d", g.is_b ? "B" : "A", g.cyc);
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            disp_e_t e;
            e = dq.pop_front();
            n_tests++;
            if (e.cyc != cyc || an !== e.an || sseg !== e.ss) begin
                n_fail++;
                $display("FAIL disp cyc=%0d an=%b sseg=%h, required an=%b sseg=%h (cyc %0d)",
                         cyc, an, sseg, e.an, e.ss, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset_n = 1'b0;
        a_req = 1'b0; a_sel = 2'd0; a_data = 8'h00;
        b_req = 1'b0; b_sel = 2'd0; b_data = 8'h00;
`ifdef SEG_PWM_EN
        brightness = 4'hF;
        bright_m   = 4'hF;
`endif
        for (int k = 0; k < 4; k++) exp_d[k] = 8'hFF;

        // Reset held for three edges: display dark, no grants.
        for (int k = 1; k <= 3; k++) exp_disp(k, 4'b1111, 8'hFF);
        tick(); tick(); tick();
        reset_n = 1'b1;
        rel = cyc;
        check_frame("scan_idle");

        // Single requester A writes digit 2.
        a_req = 1'b1; a_sel = 2'd2; a_data = 8'hC0;
        exp_gnt(cyc + 1, 1'b0);
        exp_d[2] = 8'hC0;
        tick();
        a_req = 1'b0;
        tick();
        check_frame("a_only");

        // Simultaneous requests from idle: A wins the first tie, B follows.
        a_req = 1'b1; a_sel = 2'd0; a_data = 8'h3F;
        b_req = 1'b1; b_sel = 2'd3; b_data = 8'h4F;
        exp_gnt(cyc + 1, 1'b0);
        exp_gnt(cyc + 2, 1'b1);
        tick();
        a_req = 1'b0;
        tick();
        b_req = 1'b0;
        tick(); tick();

        // Both held: tie goes to B this time, then strict alternation.
        a_data = 8'h06; b_data = 8'h5B;
        a_req = 1'b1; b_req = 1'b1;
        exp_gnt(cyc + 1, 1'b1);
        exp_gnt(cyc + 2, 1'b0);
        exp_gnt(cyc + 3, 1'b1);
        exp_gnt(cyc + 4, 1'b0);
        repeat (4) tick();
        a_req = 1'b0; b_req = 1'b0;
        exp_d[0] = 8'h06;
        exp_d[3] = 8'h5B;
        tick();
        check_frame("alternate");

        // Same target digit: A then B, B's value persists.
        a_sel = 2'd1; a_data = 8'h11;
        b_sel = 2'd1; b_data = 8'h22;
        a_req = 1'b1; b_req = 1'b1;
        exp_gnt(cyc + 1, 1'b0);
        exp_gnt(cyc + 2, 1'b1);
        tick();
        a_req = 1'b0;
        tick();
        b_req = 1'b0;
        exp_d[1] = 8'h22;
        tick();
        check_frame("same_digit");

        // Reset in the middle of slot 3 with B pending.
        i = 0;
        while (((cyc - rel - 1) % 64) != 50 && i < 70) begin
            tick();
            i++;
        end
        n_tests++;
        if (((cyc - rel - 1) % 64) != 50) begin
            n_fail++;
            $display("FAIL slot3_seek counter phase %0d, required 50", (cyc - rel - 1) % 64);
        end
        push_model(cyc);
        reset_n = 1'b0;
        b_req = 1'b1; b_sel = 2'd2; b_data = 8'h92;
        exp_disp(cyc + 1, 4'b1111, 8'hFF);
        exp_disp(cyc + 2, 4'b1111, 8'hFF);
        tick(); tick();
        reset_n = 1'b1;
        rel = cyc;
        for (int k = 0; k < 4; k++) exp_d[k] = 8'hFF;
        exp_d[2] = 8'h92;
        exp_gnt(cyc + 1, 1'b1);
        tick();
        b_req = 1'b0;
        tick();
        check_frame("reset_mid");

`ifdef SEG_PWM_EN
        brightness = 4'd4;
        bright_m   = 4'd4;
        tick();
        check_frame("pwm_4");
        brightness = 4'd0;
        bright_m   = 4'd0;
        tick();
        check_frame("pwm_0");
`endif

        tick(); tick(); tick();
        n_tests++;
        if (gq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover gq=%0d dq=%0d entries, required 0", gq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
